// File: rtl/pc_trap_unit.sv
// pc_trap_unit
//   Program counter with a misalignment trap, a single-level trap return and a
//   count of accepted PC updates.
//
//   Parameters
//     WIDTH     PC/data width in bits (must be >= 28)
//     RESET_PC  value of curPC after reset
//     TRAP_VEC  PC loaded when a misaligned target is rejected
//
//   Ports
//     CLK        in   clock, all state changes on the rising edge
//     RST        in   asynchronous active-low reset
//     PCWre      in   PC write enable; 0 holds all state
//     PCSrc      in   next-PC select: 00 seq, 01 branch, 10 jump, 11 register
//     immExt     in   sign-extended branch offset in words
//     jAddr      in   26-bit jump target field
//     rsData     in   register jump target
//     eret       in   return from trap
//     curPC      out  current PC (registered)
//     pc4        out  curPC + 4 (combinational)
//     epc        out  exception PC (registered)
//     inTrap     out  trap handler active (registered)
//     dblFault   out  sticky double-fault flag (registered)
//     instCount  out  number of accepted PC updates (registered, wraps)
module pc_trap_unit #(
    parameter int unsigned            WIDTH    = 32,
    parameter logic [WIDTH-1:0]       RESET_PC = '0,
    parameter logic [WIDTH-1:0]       TRAP_VEC = WIDTH'(32'h0000_0080)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PCWre,
    input  logic [1:0]       PCSrc,
    input  logic [WIDTH-1:0] immExt,
    input  logic [25:0]      jAddr,
    input  logic [WIDTH-1:0] rsData,
    input  logic             eret,
    output logic [WIDTH-1:0] curPC,
    output logic [WIDTH-1:0] pc4,
    output logic [WIDTH-1:0] epc,
    output logic             inTrap,
    output logic             dblFault,
    output logic [WIDTH-1:0] instCount
);

    typedef enum logic [1:0] {
        SRC_SEQ    = 2'b00,
        SRC_BRANCH = 2'b01,
        SRC_JUMP   = 2'b10,
        SRC_REG    = 2'b11
    } pc_src_e;

    logic [WIDTH-1:0] r_curPC;
    logic [WIDTH-1:0] r_epc;
    logic             r_inTrap;
    logic             r_dblFault;
    logic [WIDTH-1:0] r_instCount;

    logic [WIDTH-1:0] w_pc4;
    logic [WIDTH-1:0] w_branch;
    logic [WIDTH-1:0] w_jump;
    logic [WIDTH-1:0] w_target;
    logic             w_misaligned;
    logic             w_doEret;

    logic [WIDTH-1:0] w_nextPC;
    logic [WIDTH-1:0] w_nextEpc;
    logic             w_nextInTrap;
    logic             w_nextDblFault;

    assign w_pc4    = r_curPC + WIDTH'(4);
    assign w_branch = w_pc4 + (immExt << 2);

    // The jump keeps the upper region bits of pc4 above the 28-bit field;
    // at WIDTH == 28 there are no such bits.
    generate
        if (WIDTH > 28) begin : g_jump_wide
            assign w_jump = {w_pc4[WIDTH-1:28], jAddr, 2'b00};
        end else begin : g_jump_narrow
            assign w_jump = {jAddr, 2'b00};
        end
    endgenerate

    always_comb begin
        w_target = w_pc4;
        case (pc_src_e'(PCSrc))
            SRC_SEQ:    w_target = w_pc4;
            SRC_BRANCH: w_target = w_branch;
            SRC_JUMP:   w_target = w_jump;
            SRC_REG:    w_target = rsData;
            default:    w_target = w_pc4;
        endcase
    end

    assign w_misaligned = (w_target[1:0] != 2'b00);

    // eret outside a trap is just an ordinary load.
    assign w_doEret = eret && r_inTrap;

    // Next state for an accepted update: eret, then trap, then normal load.
    always_comb begin
        w_nextPC       = w_target;
        w_nextEpc      = r_epc;
        w_nextInTrap   = r_inTrap;
        w_nextDblFault = r_dblFault;
        if (w_doEret) begin
            w_nextPC     = r_epc;
            w_nextInTrap = 1'b0;
        end else if (w_misaligned) begin
            w_nextPC = TRAP_VEC;
            if (r_inTrap) begin
                // Fault inside the handler: keep the original return address.
                w_nextDblFault = 1'b1;
            end else begin
                w_nextEpc    = r_curPC;
                w_nextInTrap = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_curPC     <= RESET_PC;
            r_epc       <= '0;
            r_inTrap    <= 1'b0;
            r_dblFault  <= 1'b0;
            r_instCount <= '0;
        end else if (PCWre) begin
            r_curPC     <= w_nextPC;
            r_epc       <= w_nextEpc;
            r_inTrap    <= w_nextInTrap;
            r_dblFault  <= w_nextDblFault;
            r_instCount <= r_instCount + WIDTH'(1);
        end
    end

    assign curPC     = r_curPC;
    assign pc4       = w_pc4;
    assign epc       = r_epc;
    assign inTrap    = r_inTrap;
    assign dblFault  = r_dblFault;
    assign instCount = r_instCount;

endmodule

// File: tb/tb_pc_trap_unit.sv
// tb_pc_trap_unit
//   Directed testbench for pc_trap_unit with hand-computed expected values.
//   Inputs change 1 time unit after each rising edge; outputs are compared
//   at that same point, away from the active edge.
module tb_pc_trap_unit;

    localparam int W = 32;

    logic         CLK;
    logic         RST;
    logic         PCWre;
    logic [1:0]   PCSrc;
    logic [W-1:0] immExt;
    logic [25:0]  jAddr;
    logic [W-1:0] rsData;
    logic         eret;
    logic [W-1:0] curPC;
    logic [W-1:0] pc4;
    logic [W-1:0] epc;
    logic         inTrap;
    logic         dblFault;
    logic [W-1:0] instCount;

    int checks = 0;
    int errors = 0;

    pc_trap_unit #(
        .WIDTH    (W),
        .RESET_PC (32'h0000_0000),
        .TRAP_VEC (32'h0000_0080)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .PCWre     (PCWre),
        .PCSrc     (PCSrc),
        .immExt    (immExt),
        .jAddr     (jAddr),
        .rsData    (rsData),
        .eret      (eret),
        .curPC     (curPC),
        .pc4       (pc4),
        .epc       (epc),
        .inTrap    (inTrap),
        .dblFault  (dblFault),
        .instCount (instCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [W-1:0] e_pc, input logic [W-1:0] e_epc,
                             input logic e_trap, input logic e_dbl, input logic [W-1:0] e_cnt);
        chk({tag, ".curPC"},     curPC,          e_pc);
        chk({tag, ".epc"},       epc,            e_epc);
        chk({tag, ".inTrap"},    W'(inTrap),     W'(e_trap));
        chk({tag, ".dblFault"},  W'(dblFault),   W'(e_dbl));
        chk({tag, ".instCount"}, instCount,      e_cnt);
    endtask

    initial begin
        RST    = 1'b0;
        PCWre  = 1'b0;
        PCSrc  = 2'b00;
        immExt = '0;
        jAddr  = '0;
        rsData = '0;
        eret   = 1'b0;

        #3;
        chk_state("reset", 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        chk("reset.pc4", pc4, 32'h4);

        // Release between edges, then three sequential updates.
        @(negedge CLK);
        RST   = 1'b1;
        PCWre = 1'b1;
        PCSrc = 2'b00;
        step(); chk("seq1", curPC, 32'h4);
        step(); chk("seq2", curPC, 32'h8);
        step(); chk_state("seq3", 32'hC, 32'h0, 1'b0, 1'b0, 32'd3);
        step(); chk("seq4", curPC, 32'h10);

        // Backward branch: 0x14 + (-2 << 2) = 0x0C.
        PCSrc  = 2'b01;
        immExt = 32'hFFFF_FFFE;
        step(); chk("branch_back", curPC, 32'h0C);

        // Jump: pc4 = 0x10, {0x0, 0x40, 2'b00} = 0x100.
        PCSrc = 2'b10;
        jAddr = 26'h000_0040;
        step(); chk_state("jump", 32'h100, 32'h0, 1'b0, 1'b0, 32'd6);

        // Forward branch from 0x100: 0x104 + (3 << 2) = 0x110.
        PCSrc  = 2'b01;
        immExt = 32'h0000_0003;
        step(); chk("branch_fwd", curPC, 32'h110);

        // Aligned register jump to 0x20.
        PCSrc  = 2'b11;
        rsData = 32'h20;
        step(); chk("reg_aligned", curPC, 32'h20);

        // Misaligned register target traps.
        rsData = 32'h33;
        step(); chk_state("trap", 32'h80, 32'h20, 1'b1, 1'b0, 32'd9);

        // Return from trap.
        eret  = 1'b1;
        PCSrc = 2'b00;
        step(); chk_state("eret", 32'h20, 32'h20, 1'b0, 1'b0, 32'd10);

        // Trap again, then fault inside the handler.
        eret   = 1'b0;
        PCSrc  = 2'b11;
        rsData = 32'h33;
        step(); chk_state("trap2", 32'h80, 32'h20, 1'b1, 1'b0, 32'd11);
        rsData = 32'h41;
        step(); chk_state("dbl", 32'h80, 32'h20, 1'b1, 1'b1, 32'd12);

        // eret takes priority over a misaligned target and keeps dblFault.
        eret = 1'b1;
        step(); chk_state("eret_dbl", 32'h20, 32'h20, 1'b0, 1'b1, 32'd13);

        // eret outside a trap is an ordinary sequential load.
        PCSrc = 2'b00;
        step(); chk_state("eret_idle", 32'h24, 32'h20, 1'b0, 1'b1, 32'd14);

        // Write disabled: everything holds, eret ignored.
        PCWre = 1'b0;
        eret  = 1'b1;
        PCSrc = 2'b10;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_state("hold", 32'h24, 32'h20, 1'b0, 1'b1, 32'd14);
        end
        chk("hold.pc4", pc4, 32'h28);

        // Enter a trap, then reset asynchronously mid-cycle.
        PCWre  = 1'b1;
        eret   = 1'b0;
        PCSrc  = 2'b11;
        rsData = 32'h2;
        step(); chk_state("trap3", 32'h80, 32'h24, 1'b1, 1'b1, 32'd15);
        PCWre = 1'b0;
        #2;
        RST = 1'b0;
        #1;
        chk_state("async_rst", 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        #1;
        RST = 1'b1;

        // First update after release starts from RESET_PC.
        PCWre = 1'b1;
        PCSrc = 2'b00;
        step(); chk_state("post_rst", 32'h4, 32'h0, 1'b0, 1'b0, 32'd1);

        // Counter wrap: preload the count to all-ones, then one update.
        PCWre = 1'b0;
        force dut.r_instCount = 32'hFFFF_FFFF;
        #2;
        release dut.r_instCount;
        step(); chk("cnt_preload", instCount, 32'hFFFF_FFFF);
        PCWre = 1'b1;
        step(); chk("cnt_wrap", instCount, 32'h0);
        chk("cnt_wrap.curPC", curPC, 32'h8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_trap_unit.md
PC_TRAP_UNIT -- requirements
Module: pc_trap_unit

Interface
REQ-001 Parameter WIDTH, default 32, PC/data width in bits; SHALL be >= 28.
REQ-002 Parameter RESET_PC, default 0, value of curPC after reset.
REQ-003 Parameter TRAP_VEC, default 32'h0000_0080, PC loaded on a misalignment trap.
REQ-004 CLK  input  1  clock; all state changes on the rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-low.
REQ-006 PCWre  input  1  PC write enable; when 0 all state holds.
REQ-007 PCSrc  input  2  next-PC select: 00 seq, 01 branch, 10 jump, 11 register.
REQ-008 immExt  input  WIDTH  sign-extended branch offset, in words.
REQ-009 jAddr  input  26  jump target field.
REQ-010 rsData  input  WIDTH  register jump target.
REQ-011 eret  input  1  return from trap.
REQ-012 curPC  output  WIDTH  current PC, registered.
REQ-013 pc4  output  WIDTH  curPC+4, combinational.
REQ-014 epc  output  WIDTH  exception PC, registered.
REQ-015 inTrap  output  1  trap handler active, registered.
REQ-016 dblFault  output  1  sticky double-fault flag, registered.
REQ-017 instCount  output  WIDTH  count of accepted PC updates, registered.

Function
REQ-018 Candidate target SHALL be: seq = pc4; branch = pc4 + (immExt<<2); jump = {pc4[WIDTH-1:28], jAddr, 2'b00}; register = rsData; all sums SHALL be modulo 2^WIDTH.
REQ-019 An update is accepted on a rising edge with PCWre=1; with PCWre=0, curPC, epc, inTrap, dblFault and instCount SHALL hold, and eret SHALL be ignored.
REQ-020 Priority within an accepted update SHALL be eret first, then misalignment trap, then normal load.
REQ-021 eret=1 with inTrap=1: curPC <= epc and inTrap <= 0; epc SHALL be unchanged.
REQ-022 eret=1 with inTrap=0: treated as a normal load per PCSrc; eret has no other effect.
REQ-023 Misalignment: a target with bits [1:0] != 00 SHALL NOT be loaded; curPC <= TRAP_VEC instead.
REQ-024 Misalignment with inTrap=0: epc <= curPC (the faulting instruction) and inTrap <= 1.
REQ-025 Misalignment with inTrap=1: epc SHALL be kept, dblFault <= 1, inTrap stays 1.
REQ-026 Normal load: curPC <= target.
REQ-027 Once set, dblFault SHALL remain 1 until reset; eret does not clear it.
REQ-028 instCount SHALL increment by 1 on every accepted update (normal, trap or eret) and SHALL wrap from all-ones to 0.
REQ-029 Latency: a target presented in cycle N SHALL appear on curPC after the rising edge ending cycle N, with no bypass.

Reset
REQ-030 While RST=0, asynchronously and without a clock: curPC=RESET_PC, epc=0, inTrap=0, dblFault=0, instCount=0.
REQ-031 RST asserted mid-trap SHALL clear inTrap and dblFault; the first accepted update after release SHALL be computed from curPC=RESET_PC.
REQ-032 Release of RST SHALL take effect from the first rising edge at which RST=1.

Verification
REQ-033 Reset then PCWre=1, PCSrc=00 for 3 cycles -> curPC 0,4,8,C; instCount=3.
REQ-034 curPC=0x10, PCSrc=01, immExt=0xFFFFFFFE -> curPC=0x0C; then PCSrc=10, jAddr=0x0000040 -> curPC=0x100.
REQ-035 curPC=0x20, PCSrc=11, rsData=0x33 -> curPC=0x80, epc=0x20, inTrap=1; next cycle eret=1 -> curPC=0x20, inTrap=0.
REQ-036 In a trap with epc=0x20, rsData=0x41, PCSrc=11 -> curPC=0x80, epc=0x20, dblFault=1; eret -> curPC=0x20, dblFault stays 1.
REQ-037 PCWre=0 with eret=1 and PCSrc=10 for 5 cycles -> all outputs constant; RST pulsed low between clock edges -> curPC=0 immediately.
REQ-038 instCount preloaded to all-ones by driving 2^WIDTH-1 updates (or WIDTH=28 in simulation), one more update -> instCount=0.
